updn_sweep_ctrl: RTL and testbench

UPDN_SWEEP_CTRL -- requirements
Module: updn_sweep_ctrl

---
 rtl/updn_sweep_if.sv | 45 ++++
 rtl/updn_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_updn_sweep_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/updn_sweep_if.sv
// ---------------------------------------------------------------------------
// updn_sweep_if -- request/status bundle for the up/down sweep controller.
//
// Signals
//   start   requester -> controller  request a new sweep
//   abort   requester -> controller  terminate an active sweep
//   lo, hi  requester -> controller  sweep bounds (WIDTH bits)
//   cycles  requester -> controller  number of lo->hi->lo round trips
//   q       controller -> requester  current count value
//   updn    controller -> requester  1 while counting up
//   busy    controller -> requester  1 while a sweep is active
//   done    controller -> requester  one-cycle end-of-sweep pulse
//   err     controller -> requester  one-cycle pulse with done on a rejected start
//
// Handshake: start acts as "valid" and the controller is "ready" only while
// it is idle; a request is taken on any rising edge where start is high and
// the controller is idle.  A taken request is always answered by exactly one
// done pulse (with err set if the bounds or trip count were unusable), unless
// it is aborted, in which case no done pulse is produced.  start while not
// idle is simply not taken; the requester does not need to hold it.
// ---------------------------------------------------------------------------
interface updn_sweep_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [3:0]       cycles;
  logic [WIDTH-1:0] q;
  logic             updn;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, abort, lo, hi, cycles,
    input  q, updn, busy, done, err
  );

  modport slave (
    input  start, abort, lo, hi, cycles,
    output q, updn, busy, done, err
  );
endinterface

// File: rtl/updn_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// updn_sweep_ctrl -- triangle-wave counter that sweeps q from lo up to hi and
// back down to lo, repeated for a requested number of round trips.
//
// Ports
//   clk      system clock, all state changes on its rising edge
//   rst      asynchronous active-low reset (0 = reset)
//   bus      updn_sweep_if slave: start/abort/lo/hi/cycles in,
//            q/updn/busy/done/err out
//   state_o  debug view of the FSM state (IDLE=0, UP=1, DOWN=2, DONE=3)
// ---------------------------------------------------------------------------
module updn_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  updn_sweep_if.slave  bus,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       rem_q, rem_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    rem_d   = rem_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start beats abort here: abort only matters once a sweep runs.
        if (bus.start) begin
          if ((bus.lo < bus.hi) && (bus.cycles != 4'd0)) begin
            lo_d    = bus.lo;
            hi_d    = bus.hi;
            rem_d   = bus.cycles;
            q_d     = bus.lo;
            state_d = S_UP;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_UP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (q_q == hi_q) begin
          // Turn around immediately so hi is shown for a single cycle;
          // lo < hi guarantees this never underflows.
          q_d     = q_q - WIDTH'(1);
          state_d = S_DOWN;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end

      S_DOWN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (q_q != lo_q) begin
          q_d = q_q - WIDTH'(1);
        end else if (rem_q > 4'd1) begin
          rem_d   = rem_q - 4'd1;
          q_d     = q_q + WIDTH'(1);
          state_d = S_UP;
        end else begin
          // Last trip finished: park on lo and report.
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.q    = q_q;
  assign bus.updn = (state_q == S_UP);
  assign bus.busy = (state_q == S_UP) || (state_q == S_DOWN);
  assign bus.done = (state_q == S_DONE);
  // err_q is only ever set on the transition into DONE, so it lines up
  // with the done pulse and clears on the following edge.
  assign bus.err  = err_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_updn_sweep_ctrl.sv
module tb_updn_sweep_ctrl;

  localparam int WIDTH = 4;

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] cyc;
    logic       exp_err;
    int         exp_len;
    logic [3:0] exp_q;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] st;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] model_q = '0;

  logic [WIDTH-1:0] exp_q[$];
  logic             exp_u[$];

  vec_t vecs[8];

  updn_sweep_if #(.WIDTH(WIDTH)) bus_if ();

  updn_sweep_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if.slave),
    .state_o (st)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input int exp_q_val);
    chk({tag, "_q"}, int'(bus_if.q), exp_q_val);
    chk({tag, "_busy"}, int'(bus_if.busy), 0);
    chk({tag, "_updn"}, int'(bus_if.updn), 0);
    chk({tag, "_done"}, int'(bus_if.done), 0);
    chk({tag, "_err"}, int'(bus_if.err), 0);
  endtask

  // Reference: a sweep of d = hi-lo over c trips visits, at step t after the
  // accepting edge, lo + triangle(t mod 2d). The direction flag is set on the
  // first step and on every rising-leg point after a trip boundary.
  task automatic build_expect(input int l, input int h, input int c);
    int d;
    int ph;
    d = h - l;
    exp_q.delete();
    exp_u.delete();
    for (int t = 0; t <= 2 * d * c; t++) begin
      ph = t % (2 * d);
      exp_q.push_back(WIDTH'((ph <= d) ? (l + ph) : (l + 2 * d - ph)));
      exp_u.push_back((t == 0) || (ph >= 1 && ph <= d));
    end
  endtask

  // driver: one full request, checked cycle by cycle against the model.
  // With noise set, bounds/trip count and start are scrambled during the sweep.
  task automatic sweep(input logic [3:0] l, input logic [3:0] h,
                       input logic [3:0] c, input bit noise);
    logic [WIDTH-1:0] eq;
    logic             eu;
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.abort  = 1'b0;
    bus_if.lo     = l;
    bus_if.hi     = h;
    bus_if.cycles = c;
    @(negedge clk);
    bus_if.start = 1'b0;
    if (l >= h || c == 4'd0) begin
      chk("rej_done", int'(bus_if.done), 1);
      chk("rej_err", int'(bus_if.err), 1);
      chk("rej_busy", int'(bus_if.busy), 0);
      chk("rej_q", int'(bus_if.q), int'(model_q));
      @(negedge clk);
      chk_idle_outputs("rej_after", int'(model_q));
      return;
    end
    build_expect(int'(l), int'(h), int'(c));
    while (exp_q.size() > 0) begin
      eq = exp_q.pop_front();
      eu = exp_u.pop_front();
      chk("sw_q", int'(bus_if.q), int'(eq));
      chk("sw_updn", int'(bus_if.updn), int'(eu));
      chk("sw_busy", int'(bus_if.busy), 1);
      chk("sw_done", int'(bus_if.done), 0);
      if (noise) begin
        bus_if.lo     = 4'($urandom_range(0, 15));
        bus_if.hi     = 4'($urandom_range(0, 15));
        bus_if.cycles = 4'($urandom_range(0, 15));
        bus_if.start  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    chk("sw_end_done", int'(bus_if.done), 1);
    chk("sw_end_err", int'(bus_if.err), 0);
    chk("sw_end_busy", int'(bus_if.busy), 0);
    chk("sw_end_q", int'(bus_if.q), int'(l));
    model_q = l;
    @(negedge clk);
    chk_idle_outputs("sw_after", int'(l));
  endtask

  // driver: table vector, checked against its recorded busy length and end state
  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.lo     = v.lo;
    bus_if.hi     = v.hi;
    bus_if.cycles = v.cyc;
    @(negedge clk);
    bus_if.start = 1'b0;
    while (bus_if.busy === 1'b1 && n < 600) begin
      n++;
      @(negedge clk);
    end
    chk("vec_busy_len", n, v.exp_len);
    chk("vec_done", int'(bus_if.done), 1);
    chk("vec_err", int'(bus_if.err), int'(v.exp_err));
    chk("vec_q", int'(bus_if.q), int'(v.exp_q));
    bus_if.abort = 1'b1;  // abort in DONE must not change anything
    @(negedge clk);
    bus_if.abort = 1'b0;
    chk_idle_outputs("vec_after", int'(v.exp_q));
    model_q = v.exp_q;
  endtask

  initial begin
    int n;
    vecs[0] = '{lo: 4'd2,  hi: 4'd5,  cyc: 4'd2, exp_err: 1'b0, exp_len: 13, exp_q: 4'd2};
    vecs[1] = '{lo: 4'd7,  hi: 4'd7,  cyc: 4'd3, exp_err: 1'b1, exp_len: 0,  exp_q: 4'd2};
    vecs[2] = '{lo: 4'd0,  hi: 4'd15, cyc: 4'd1, exp_err: 1'b0, exp_len: 31, exp_q: 4'd0};
    vecs[3] = '{lo: 4'd5,  hi: 4'd9,  cyc: 4'd0, exp_err: 1'b1, exp_len: 0,  exp_q: 4'd0};
    vecs[4] = '{lo: 4'd14, hi: 4'd15, cyc: 4'd3, exp_err: 1'b0, exp_len: 7,  exp_q: 4'd14};
    vecs[5] = '{lo: 4'd9,  hi: 4'd3,  cyc: 4'd1, exp_err: 1'b1, exp_len: 0,  exp_q: 4'd14};
    vecs[6] = '{lo: 4'd0,  hi: 4'd1,  cyc: 4'd1, exp_err: 1'b0, exp_len: 3,  exp_q: 4'd0};
    vecs[7] = '{lo: 4'd7,  hi: 4'd7,  cyc: 4'd0, exp_err: 1'b1, exp_len: 0,  exp_q: 4'd0};

    rst           = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.abort  = 1'b0;
    bus_if.lo     = '0;
    bus_if.hi     = '0;
    bus_if.cycles = '0;
    #7;
    chk_idle_outputs("reset", 0);
    chk("reset_state", int'(st), 0);
    @(negedge clk);
    rst = 1'b1;

    // lo=2, hi=5, two trips, exact sequence
    sweep(4'd2, 4'd5, 4'd2, 1'b0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // random sweeps with input noise (start while busy, changing bounds)
    for (int i = 0; i < 30; i++) begin
      sweep(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 3)), 1'b1);
    end

    // abort on a rising leg at q=4
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.lo     = 4'd1;
    bus_if.hi     = 4'd6;
    bus_if.cycles = 4'd2;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_q", int'(bus_if.q), 4);
    chk("abort_pre_updn", int'(bus_if.updn), 1);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    chk_idle_outputs("abort", 4);
    @(negedge clk);
    chk_idle_outputs("abort_after", 4);

    // start and abort together in IDLE: start wins, then abort stops it
    bus_if.start  = 1'b1;
    bus_if.abort  = 1'b1;
    bus_if.lo     = 4'd3;
    bus_if.hi     = 4'd8;
    bus_if.cycles = 4'd1;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk("start_abort_busy", int'(bus_if.busy), 1);
    chk("start_abort_q", int'(bus_if.q), 3);
    @(negedge clk);
    bus_if.abort = 1'b0;
    chk_idle_outputs("start_abort_after", 3);

    // reset mid-sweep, away from a clock edge
    bus_if.start  = 1'b1;
    bus_if.lo     = 4'd3;
    bus_if.hi     = 4'd12;
    bus_if.cycles = 4'd2;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", int'(bus_if.busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_idle_outputs("mid_rst", 0);
    @(negedge clk);
    chk_idle_outputs("mid_rst_hold", 0);
    rst           = 1'b1;
    bus_if.start  = 1'b1;
    bus_if.lo     = 4'd2;
    bus_if.hi     = 4'd4;
    bus_if.cycles = 4'd1;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk("post_rst_q", int'(bus_if.q), 2);
    chk("post_rst_busy", int'(bus_if.busy), 1);
    n = 0;
    while (bus_if.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("post_rst_len", n, 5);
    chk("post_rst_done", int'(bus_if.done), 1);
    chk("post_rst_end_q", int'(bus_if.q), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
